// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides: single-cycle logic and
// add/sub, and a BITSIZE-cycle shift-add unsigned multiplier. Results are held until taken.
module alu_seq #(
   parameter int unsigned BITSIZE = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BITSIZE-1:0] A,
   input  logic [BITSIZE-1:0] B,
   input  logic [3:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITSIZE-1:0] Y,
   output logic [BITSIZE-1:0] YH,
   output logic [15:0]        flags
);

   localparam int unsigned CW = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_MULU = 4'b0110;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [BITSIZE-1:0]   a_r;
   logic [BITSIZE-1:0]   b_r;
   logic [3:0]           op_r;
   logic [2*BITSIZE-1:0] acc;
   logic [CW-1:0]        cnt;

   logic [BITSIZE-1:0]   b_eff;
   logic [BITSIZE-1:0]   sum;
   logic                 cout;
   logic                 msb_cin;
   logic                 ovf;
   logic [BITSIZE-1:0]   ex_y;
   logic                 ex_c;
   logic                 ex_low;
   logic                 ex_ov;
   logic                 ex_err;
   logic [15:0]          ex_flags;

   logic [BITSIZE:0]     mul_part;
   logic [2*BITSIZE-1:0] mul_next;
   logic                 mul_last;
   logic [15:0]          mul_flags;

   function automatic logic [15:0] mk_flags(input logic c, input logic low, input logic ov,
                                            input logic z, input logic n, input logic err);
      logic [15:0] f;
      f    = '0;
      f[0] = c;
      f[2] = low;
      f[5] = ov;
      f[6] = z;
      f[7] = n;
      f[9] = err;
      return f;
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Shared adder: SUB is A + ~B + 1, so carry-out set means no borrow.
   always_comb begin
      b_eff         = (op_r == OP_SUB) ? ~b_r : b_r;
      {cout, sum}   = {1'b0, a_r} + {1'b0, b_eff}
                    + {{BITSIZE{1'b0}}, (op_r == OP_SUB)};
      msb_cin       = a_r[BITSIZE-1] ^ b_eff[BITSIZE-1] ^ sum[BITSIZE-1];
      ovf           = msb_cin ^ cout;
   end

   always_comb begin
      ex_y   = '0;
      ex_c   = 1'b0;
      ex_low = 1'b0;
      ex_ov  = 1'b0;
      ex_err = 1'b0;
      case (op_r)
         OP_ADD: begin
            ex_y  = sum;
            ex_c  = cout;
            ex_ov = ovf;
         end
         OP_SUB: begin
            ex_y   = sum;
            ex_low = ~cout;
            ex_ov  = ovf;
         end
         OP_AND:  ex_y = a_r & b_r;
         OP_OR:   ex_y = a_r | b_r;
         OP_XOR:  ex_y = a_r ^ b_r;
         OP_NOR:  ex_y = ~(a_r | b_r);
         default: ex_err = 1'b1;
      endcase
      ex_flags = mk_flags(ex_c, ex_low, ex_ov, (ex_y == '0), ex_y[BITSIZE-1], ex_err);
   end

   // Multiplier lives in the low half of acc; each step consumes acc[0] and shifts right.
   always_comb begin
      mul_part  = {1'b0, acc[2*BITSIZE-1:BITSIZE]} + (acc[0] ? {1'b0, a_r} : '0);
      mul_next  = {mul_part, acc[BITSIZE-1:1]};
      mul_last  = (cnt == CW'(BITSIZE - 1));
      mul_flags = mk_flags((mul_next[2*BITSIZE-1:BITSIZE] != '0), 1'b0, 1'b0,
                           (mul_next == '0), mul_next[2*BITSIZE-1], 1'b0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = (op == OP_MULU) ? MUL : EXEC;
            end
         end
         EXEC: state_nxt = DONE;
         MUL: begin
            if (mul_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= '0;
         acc   <= '0;
         cnt   <= '0;
         Y     <= '0;
         YH    <= '0;
         flags <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r  <= A;
                  b_r  <= B;
                  op_r <= op;
                  acc  <= {{BITSIZE{1'b0}}, B};
                  cnt  <= '0;
               end
            end
            EXEC: begin
               Y     <= ex_y;
               YH    <= '0;
               flags <= ex_flags;
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + 1'b1;
               if (mul_last) begin
                  Y     <= mul_next[BITSIZE-1:0];
                  YH    <= mul_next[2*BITSIZE-1:BITSIZE];
                  flags <= mul_flags;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at BITSIZE=16: hand-computed results, flags, latency,
// back-pressure hold, illegal op and asynchronous reset during a multiply.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Y;
   logic [15:0] YH;
   logic [15:0] flags;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   alu_seq #(.BITSIZE(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .YH        (YH),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Latency counts the accept edge as edge 1.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] o, input int lat, input logic [15:0] ey,
                         input logic [15:0] eyh, input logic [15:0] ef, input int stall);
      int edges;
      @(negedge clk);
      chk({tag, "_in_ready_idle"}, in_ready, 1);
      A = a; B = b; op = o; in_valid = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 1'b0; A = ~a; B = ~b; op = 4'hF;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, edges, lat);
      chk({tag, "_Y"}, Y, ey);
      chk({tag, "_YH"}, YH, eyh);
      chk({tag, "_flags"}, flags, ef);
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      repeat (stall) begin
         in_valid = 1'b1; A = 16'h0001; B = 16'h0001; op = 4'b0000;
         @(posedge clk);
         @(negedge clk);
      end
      if (stall > 0) begin
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_Y"}, Y, ey);
         chk({tag, "_hold_flags"}, flags, ef);
         chk({tag, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_released_valid"}, out_valid, 0);
      chk({tag, "_released_in_ready"}, in_ready, 1);
      chk({tag, "_idle_Y_held"}, Y, ey);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_no_spurious"}, out_valid, 0);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; op = '0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_Y", Y, 0);
      chk("reset_YH", YH, 0);
      chk("reset_flags", flags, 0);
      rst_n = 1'b1;

      run_op("add_ovf",   16'h7FFF, 16'h0001, 4'b0000, 2,  16'h8000, 16'h0000, 16'h00A0, 0);
      run_op("sub_low",   16'h0003, 16'h0005, 4'b0001, 2,  16'hFFFE, 16'h0000, 16'h0084, 0);
      run_op("sub_zero",  16'h0005, 16'h0005, 4'b0001, 2,  16'h0000, 16'h0000, 16'h0040, 0);
      run_op("mul_max",   16'hFFFF, 16'hFFFF, 4'b0110, 17, 16'h0001, 16'hFFFE, 16'h0081, 0);
      run_op("and",       16'hF0F0, 16'hFF00, 4'b0010, 2,  16'hF000, 16'h0000, 16'h0080, 0);
      run_op("or",        16'h0F0F, 16'h00F0, 4'b0011, 2,  16'h0FFF, 16'h0000, 16'h0000, 0);
      run_op("xor",       16'hAAAA, 16'hAAAA, 4'b0100, 2,  16'h0000, 16'h0000, 16'h0040, 0);
      run_op("nor",       16'h0000, 16'h0000, 4'b0101, 2,  16'hFFFF, 16'h0000, 16'h0080, 0);
      run_op("mul_small", 16'h0003, 16'h0005, 4'b0110, 17, 16'h000F, 16'h0000, 16'h0000, 0);

      // Reset mid-multiply, away from any clock edge.
      @(negedge clk);
      A = 16'hFFFF; B = 16'hFFFF; op = 4'b0110; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midmul_rst_out_valid", out_valid, 0);
      chk("midmul_rst_Y", Y, 0);
      chk("midmul_rst_YH", YH, 0);
      chk("midmul_rst_flags", flags, 0);
      chk("midmul_rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midmul_no_result", seen, 0);

      run_op("add_after_rst", 16'h0002, 16'h0003, 4'b0000, 2, 16'h0005, 16'h0000, 16'h0000, 0);
      run_op("illegal",       16'h1234, 16'h5678, 4'b1010, 2, 16'h0000, 16'h0000, 16'h0240, 0);
      run_op("add_stall",     16'hFFFF, 16'h0001, 4'b0000, 2, 16'h0000, 16'h0000, 16'h0041, 5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter BITSIZE, default 16, SHALL set operand/result width; legal range 4..32.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  SHALL mark A, B, op as valid.
REQ-005 Port in_ready  output  1  SHALL indicate the block accepts a new operation.
REQ-006 Port A  input  BITSIZE  SHALL be operand 1.
REQ-007 Port B  input  BITSIZE  SHALL be operand 2.
REQ-008 Port op  input  4  SHALL select the operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 MULU; 0111-1111 illegal.
REQ-009 Port out_valid  output  1  SHALL mark Y, YH, flags as valid.
REQ-010 Port out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-011 Port Y  output  BITSIZE  SHALL be the result (MULU: low half of product).
REQ-012 Port YH  output  BITSIZE  SHALL be MULU high half of product; 0 for all other ops.
REQ-013 Port flags  output  16  SHALL be the registered flag word (layout REQ-022).

Function
REQ-014 Operation accepted SHALL occur on a rising edge with in_valid=1 and in_ready=1; A, B, op captured into internal registers at that edge.
REQ-015 State machine SHALL have states IDLE, EXEC, MUL, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE -> EXEC on accept with op != 0110; IDLE -> MUL on accept with op = 0110; otherwise remain IDLE.
REQ-018 EXEC SHALL compute result and flags in one cycle and move to DONE; out_valid asserts the cycle after EXEC (2 edges after accept).
REQ-019 MUL SHALL run an unsigned shift-add over exactly BITSIZE cycles (one multiplier bit per cycle, LSB first, 2*BITSIZE-bit accumulator), then move to DONE; out_valid asserts BITSIZE+1 edges after accept.
REQ-020 DONE SHALL hold out_valid=1 and Y, YH, flags stable until out_ready=1 on an edge, then go to IDLE; in_ready is 1 the following cycle.
REQ-021 ADD/SUB SHALL use a BITSIZE-wide adder: SUB = A + ~B + 1; results modulo 2^BITSIZE.
REQ-022 flags bit 0 Carry = adder carry-out, ADD only; bit 2 Low = NOT carry-out, SUB only (A<B unsigned); bit 5 Overflow = carry-in XOR carry-out of MSB, ADD/SUB only; bit 6 Zero = (Y==0) and, for MULU, (YH==0); bit 7 Negative = Y[BITSIZE-1] (MULU: YH[BITSIZE-1]); bit 9 Error = illegal op; all other bits 0.
REQ-023 Logic ops SHALL produce Carry=Low=Overflow=0; MULU SHALL produce Carry=1 iff YH != 0, Low=Overflow=0.
REQ-024 Illegal op SHALL go through EXEC, produce Y=0, YH=0, flags = only bits 6 and 9 set.
REQ-025 Y, YH, flags SHALL change only on the EXEC->DONE or MUL->DONE transition; they hold last values while IDLE.
REQ-026 in_valid while not in IDLE SHALL be ignored (no capture, no state change).
REQ-027 Operand changes after accept SHALL not affect the in-flight result.

Reset
REQ-028 rst_n=0 SHALL immediately, regardless of clk, force state IDLE, in_ready=1 after release, out_valid=0, Y=0, YH=0, flags=0, multiply counter and accumulator 0.
REQ-029 Reset asserted mid-MUL or in DONE SHALL discard the operation; no result is presented after release.
REQ-030 After rst_n rises, first accept is allowed on the first rising edge with rst_n=1.

Verification (BITSIZE=16)
REQ-031 ADD A=7FFF B=0001, out_ready=1 -> out_valid 2 edges after accept, Y=8000, flags=00A0 (Overflow, Negative).
REQ-032 SUB A=0003 B=0005 -> Y=FFFE, flags=0084 (Low, Negative); SUB A=5 B=5 -> Y=0000, flags=0040.
REQ-033 MULU A=FFFF B=FFFF -> out_valid exactly 17 edges after accept, Y=0001, YH=FFFE, flags=0081 (Carry, Negative).
REQ-034 ADD FFFF+0001 with out_ready=0 for 5 cycles -> Y=0000, flags=0041 held stable, in_ready=0, new in_valid ignored; completes on out_ready=1.
REQ-035 op=1010 -> Y=0000, YH=0000, flags=0240.
REQ-036 rst_n pulsed low at MUL cycle 8 -> out_valid=0, all outputs 0 immediately; next ADD 0002+0003 yields Y=0005, flags=0000.
